// File: rtl/bus_arbiter.sv
// bus_arbiter: three-requester memory bus arbiter with a grant watchdog.
// Requester 1 = page walker, 2 = instruction/data fetch, 3 = store write-back.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration starting at a rotating pointer
//   undefined -> fixed priority 1 > 2 > 3 (no pointer state at all)
// All outputs come straight from flops; nothing combinational reaches a port.
module bus_arbiter #(
   parameter int GRANT_WAIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bus_reqcyc1,
   input  logic       bus_reqcyc2,
   input  logic       bus_reqcyc3,
   input  logic       bus_busy,
   output logic       bus_grant1,
   output logic       bus_grant2,
   output logic       bus_grant3,
   output logic [1:0] out_owner,
   output logic       out_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2
   } arbState_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(GRANT_WAIT - 1);

   arbState_t  state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [2:0] grant_q, grant_d;
   logic       timeout_q, timeout_d;
   logic [7:0] waitCnt_q, waitCnt_d;
   logic [2:0] reqVec;
   logic [1:0] pick;
   logic       ownerReq;
   logic       release_c;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;
`endif

   assign reqVec = {bus_reqcyc3, bus_reqcyc2, bus_reqcyc1};

   // Choose the winning requester from the requests present at this edge.
   always_comb begin
      pick = 2'd0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      case (ptr_q)
         2'd2: begin
            if (reqVec[1])      pick = 2'd2;
            else if (reqVec[2]) pick = 2'd3;
            else if (reqVec[0]) pick = 2'd1;
         end
         2'd3: begin
            if (reqVec[2])      pick = 2'd3;
            else if (reqVec[0]) pick = 2'd1;
            else if (reqVec[1]) pick = 2'd2;
         end
         default: begin
            if (reqVec[0])      pick = 2'd1;
            else if (reqVec[1]) pick = 2'd2;
            else if (reqVec[2]) pick = 2'd3;
         end
      endcase
`else
      if (reqVec[0])      pick = 2'd1;
      else if (reqVec[1]) pick = 2'd2;
      else if (reqVec[2]) pick = 2'd3;
`endif
   end

   // Is the current owner still asserting its request line?
   always_comb begin
      case (owner_q)
         2'd1:    ownerReq = bus_reqcyc1;
         2'd2:    ownerReq = bus_reqcyc2;
         2'd3:    ownerReq = bus_reqcyc3;
         default: ownerReq = 1'b0;
      endcase
   end

   // Next-state logic: grant, hold through the transfer, release or time out.
   // A busy bus always beats both a dropped request and the watchdog, and a
   // dropped request beats the watchdog so a voluntary release never pulses.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      waitCnt_d = waitCnt_q;
      timeout_d = 1'b0;
      release_c = 1'b0;
      case (state_q)
         IDLE: begin
            owner_d   = 2'd0;
            waitCnt_d = 8'd0;
            if (!bus_busy && (pick != 2'd0)) begin
               state_d = GRANT;
               owner_d = pick;
            end
         end
         GRANT: begin
            if (bus_busy) begin
               state_d = BUSY;
            end else if (!ownerReq) begin
               release_c = 1'b1;
            end else if (waitCnt_q == WAIT_LIMIT) begin
               release_c = 1'b1;
               timeout_d = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end
         BUSY: begin
            if (!bus_busy) begin
               release_c = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = 2'd0;
         end
      endcase
      if (release_c) begin
         state_d   = IDLE;
         owner_d   = 2'd0;
         waitCnt_d = 8'd0;
      end
   end

   // One-hot grant decoded from the next owner so the grant flops track it.
   always_comb begin
      grant_d = 3'b000;
      case (owner_d)
         2'd1:    grant_d = 3'b001;
         2'd2:    grant_d = 3'b010;
         2'd3:    grant_d = 3'b100;
         default: grant_d = 3'b000;
      endcase
   end

`ifdef BUS_ARB_ROUND_ROBIN_EN
   // Pointer moves to the requester after the one that just gave up the bus.
   always_comb begin
      ptr_d = ptr_q;
      if (release_c) begin
         ptr_d = (owner_q == 2'd3) ? 2'd1 : owner_q + 2'd1;
      end
   end

   // Round-robin pointer register; requester 1 is searched first after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 2'd1;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Main state and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= 2'd0;
         grant_q   <= 3'b000;
         timeout_q <= 1'b0;
         waitCnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         timeout_q <= timeout_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   assign bus_grant1  = grant_q[0];
   assign bus_grant2  = grant_q[1];
   assign bus_grant3  = grant_q[2];
   assign out_owner   = owner_q;
   assign out_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter's ownership rules.
module tb_bus_arbiter;

   localparam int GW = 4;

   logic       clk;
   logic       reset;
   logic       req1, req2, req3;
   logic       busy;
   logic       grant1, grant2, grant3;
   logic [1:0] owner;
   logic       timeout;

   int tests    = 0;
   int failures = 0;

   bus_arbiter #(.GRANT_WAIT(GW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_reqcyc1 (req1),
      .bus_reqcyc2 (req2),
      .bus_reqcyc3 (req3),
      .bus_busy    (busy),
      .bus_grant1  (grant1),
      .bus_grant2  (grant2),
      .bus_grant3  (grant3),
      .out_owner   (owner),
      .out_timeout (timeout)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: who owns the bus, whether a transfer has started, how long the
   // owner has waited, and where the fair search begins next time.
   int mOwner   = 0;
   int mPtr     = 1;
   int mWait    = 0;
   bit mInBusy  = 0;
   bit mTimeout = 0;
   bit mValid   = 0;

   function automatic int pickModel(input bit [3:1] r, input int ptr);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 3; i++) begin
         int c;
         c = ((ptr - 1 + i) % 3) + 1;
         if (r[c]) return c;
      end
      return 0;
`else
      for (int c = 1; c <= 3; c++) begin
         if (r[c]) return c;
      end
      return ptr * 0;
`endif
   endfunction

   // Advance the model on every rising edge from the sampled inputs.
   always @(posedge clk) begin : modelStep
      int nOwner, nPtr, nWait;
      bit nInBusy, nTimeout, released;
      bit [3:1] r;
      nOwner   = mOwner;
      nPtr     = mPtr;
      nWait    = mWait;
      nInBusy  = mInBusy;
      nTimeout = 0;
      released = 0;
      r        = {req3, req2, req1};
      if (reset) begin
         nOwner  = 0;
         nPtr    = 1;
         nWait   = 0;
         nInBusy = 0;
      end else if (mOwner == 0) begin
         if (!busy && r != 3'b000) begin
            nOwner  = pickModel(r, mPtr);
            nWait   = 0;
            nInBusy = 0;
         end
      end else if (!mInBusy) begin
         if (busy) nInBusy = 1;
         else if (!r[mOwner]) released = 1;
         else if (mWait == GW - 1) begin
            released = 1;
            nTimeout = 1;
         end else nWait = mWait + 1;
      end else if (!busy) begin
         released = 1;
      end
      if (released) begin
         nPtr    = (mOwner % 3) + 1;
         nOwner  = 0;
         nWait   = 0;
         nInBusy = 0;
      end
      mOwner   <= nOwner;
      mPtr     <= nPtr;
      mWait    <= nWait;
      mInBusy  <= nInBusy;
      mTimeout <= nTimeout;
      if (reset) mValid <= 1;
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (mValid) begin
         logic [2:0] expG;
         logic [2:0] g;
         logic [1:0] decOwner;
         expG = 3'b000;
         if (mOwner != 0) expG[mOwner - 1] = 1'b1;
         g = {grant3, grant2, grant1};
         tests++;
         if (g !== expG || owner !== 2'(mOwner) || timeout !== mTimeout) begin
            failures++;
            $display("[TB] FAIL modelCompare t=%0t got grants=%b owner=%0d timeout=%b, expected grants=%b owner=%0d timeout=%b",
                     $time, g, owner, timeout, expG, mOwner, mTimeout);
         end
         decOwner = g[0] ? 2'd1 : g[1] ? 2'd2 : g[2] ? 2'd3 : 2'd0;
         tests++;
         if (!$onehot0(g) || decOwner !== owner) begin
            failures++;
            $display("[TB] FAIL grantConsistency t=%0t grants=%b owner=%0d, expected one-hot-or-zero grants matching owner",
                     $time, g, owner);
         end
      end
   end

   // Drive the inputs for the next edge and move just past that edge.
   task automatic applyStimulus(input logic r, input logic q1, input logic q2,
                                input logic q3, input logic b);
      reset = r;
      req1  = q1;
      req2  = q2;
      req3  = q3;
      busy  = b;
      @(posedge clk);
      #1;
   endtask

   // Literal expectation checked just after an edge.
   task automatic checkOutput(input string name, input logic [2:0] expG,
                              input logic [1:0] expO, input logic expT);
      tests++;
      if ({grant3, grant2, grant1} !== expG || owner !== expO || timeout !== expT) begin
         failures++;
         $display("[TB] FAIL %s got grants=%b owner=%0d timeout=%b, expected grants=%b owner=%0d timeout=%b",
                  name, {grant3, grant2, grant1}, owner, timeout, expG, expO, expT);
      end
   endtask

   int expSeq[4];

   initial begin
      reset = 1'b1;
      req1 = 0; req2 = 0; req3 = 0; busy = 0;

      // Reset state.
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("resetState", 3'b000, 2'd0, 1'b0);

      // Grant to 1, busy transfer in cycles 2..5, release in cycle 7.
      applyStimulus(0, 1, 0, 0, 0);               // edge 0 -> cycle 1
      checkOutput("req1GrantCycle1", 3'b001, 2'd1, 1'b0);
      applyStimulus(0, 1, 0, 0, 0);               // edge 1 -> cycle 2
      applyStimulus(0, 1, 0, 0, 1);               // edge 2 -> cycle 3
      applyStimulus(0, 1, 0, 0, 1);               // edge 3
      applyStimulus(0, 1, 0, 0, 1);               // edge 4
      applyStimulus(0, 0, 0, 0, 1);               // edge 5 -> cycle 6
      checkOutput("req1HeldInBusy", 3'b001, 2'd1, 1'b0);
      applyStimulus(0, 0, 0, 0, 0);               // edge 6 -> cycle 7
      checkOutput("req1ReleasedCycle7", 3'b000, 2'd0, 1'b0);

      // Watchdog: req2 held, no busy.
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);               // cycle 1
      checkOutput("wdGrantCycle1", 3'b010, 2'd2, 1'b0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);               // cycle 4
      checkOutput("wdGrantCycle4", 3'b010, 2'd2, 1'b0);
      applyStimulus(0, 0, 1, 0, 0);               // cycle 5
      checkOutput("wdTimeoutCycle5", 3'b000, 2'd0, 1'b1);
      applyStimulus(0, 0, 0, 0, 0);               // cycle 6
      checkOutput("wdPulseOneCycle", 3'b000, 2'd0, 1'b0);

      // Short pulse on req2: one-cycle grant, no timeout.
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("pulseGrant", 3'b010, 2'd2, 1'b0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("pulseRelease", 3'b000, 2'd0, 1'b0);

      // Reset during a busy transfer owned by requester 3.
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("grant3", 3'b100, 2'd3, 1'b0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("grant3Busy", 3'b100, 2'd3, 1'b0);
      applyStimulus(1, 0, 0, 1, 1);
      checkOutput("resetMidBusy", 3'b000, 2'd0, 1'b0);
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput("afterResetPtr1", 3'b001, 2'd1, 1'b0);
      applyStimulus(0, 0, 0, 0, 0);

      // Busy while idle blocks new grants until it falls.
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("busyBlocksGrant", 3'b000, 2'd0, 1'b0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("grantAfterBusyFalls", 3'b010, 2'd2, 1'b0);
      applyStimulus(0, 0, 0, 0, 0);

      // All three requesting continuously, 3-cycle busy bursts.
`ifdef BUS_ARB_ROUND_ROBIN_EN
      expSeq = '{1, 2, 3, 1};
`else
      expSeq = '{1, 1, 1, 1};
`endif
      applyStimulus(1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         logic [2:0] eg;
         eg = 3'b000;
         eg[expSeq[k] - 1] = 1'b1;
         applyStimulus(0, 1, 1, 1, 0);
         checkOutput($sformatf("arbRound%0d", k), eg, 2'(expSeq[k]), 1'b0);
         applyStimulus(0, 1, 1, 1, 1);
         applyStimulus(0, 1, 1, 1, 1);
         applyStimulus(0, 1, 1, 1, 1);
         applyStimulus(0, 1, 1, 1, 0);
         checkOutput($sformatf("arbIdleGap%0d", k), 3'b000, 2'd0, 1'b0);
      end

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(0, 199) == 0),
                       ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 9) < 3));
      end

      applyStimulus(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter GRANT_WAIT, default 16: max cycles a granted requester may hold grant without raising bus_busy; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bus_reqcyc1 / bus_reqcyc2 / bus_reqcyc3  input  1 each  requester N wants the memory bus (1 = page walker, 2 = instruction/data fetch, 3 = store write-back).
REQ-005 bus_busy  input  1  OR of all requesters' busy flags; high while the owner has a transaction in flight.
REQ-006 bus_grant1 / bus_grant2 / bus_grant3  output  1 each  registered one-hot grant; at most one high in any cycle.
REQ-007 out_owner  output  2  registered index of current grantee: 0 = none, 1..3 = requester.
REQ-008 out_timeout  output  1  registered one-cycle pulse when a grant is revoked by the GRANT_WAIT watchdog.

Function
REQ-009 FSM states: IDLE, GRANT, BUSY; no other reachable states.
REQ-010 IDLE: all grants 0, out_owner 0; if any bus_reqcycN=1 at an edge, SHALL enter GRANT with the selected requester's grant high from the next cycle (1-cycle request-to-grant latency).
REQ-011 Selection from the requests sampled at the IDLE edge only; requests arriving later wait for the next IDLE.
REQ-012 GRANT: grant held; bus_busy=1 at an edge -> BUSY, grant held.
REQ-013 GRANT: owner's bus_reqcyc=0 and bus_busy=0 at an edge -> IDLE, grant dropped next cycle, no timeout pulse.
REQ-014 GRANT: 8-bit wait counter cleared on entry, increments each cycle in GRANT; when counter = GRANT_WAIT-1 and bus_busy=0 -> IDLE, grant dropped, out_timeout=1 for exactly one cycle.
REQ-015 bus_busy=1 in the same cycle as the watchdog limit: busy wins, enter BUSY, no timeout.
REQ-016 BUSY: grant held regardless of bus_reqcycN; bus_busy=0 at an edge -> IDLE, grant drops next cycle.
REQ-017 At least one IDLE cycle (all grants 0) between consecutive grants, even to the same requester.
REQ-018 bus_busy high while in IDLE is ignored for state, but SHALL block new grants until it falls.
REQ-019 Priority per REQ-026/REQ-027; the priority pointer updates only on leaving GRANT or BUSY.
REQ-020 bus_reqcycN changes during BUSY SHALL NOT change owner or grants.

Reset
REQ-021 reset=1 at an edge: state IDLE, all bus_grantN=0, out_owner=0, out_timeout=0, wait counter 0, round-robin pointer -> requester 1 (highest).
REQ-022 Reset overrides every transition including mid-GRANT or mid-BUSY; grants low the cycle after the reset edge.
REQ-023 No grant issued in the cycle following reset deassertion unless a request is sampled at that first non-reset edge.
REQ-024 Outputs are registered only; no combinational path from any input to any output.

Configuration
REQ-025 Macro BUS_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-026 Defined: round-robin; search order starts at pointer; on leaving GRANT/BUSY the pointer moves to owner+1 (3 wraps to 1).
REQ-027 Undefined: fixed priority 1 > 2 > 3; pointer logic absent; all other behaviour identical.

Verification
REQ-028 Reset, then req1=1 at edge 0 -> grant1=1, out_owner=1 from cycle 1; bus_busy 1 for cycles 2..5 -> grant1=0 in cycle 7, out_owner=0.
REQ-029 req1=req2=req3=1 continuously, each busy burst 3 cycles: round-robin build grants 1,2,3,1 with one idle cycle between; fixed build grants 1 every time.
REQ-030 GRANT_WAIT=4, req2=1, bus_busy never high -> grant2 high cycles 1..4, out_timeout=1 in cycle 5 only, grant2=0 in cycle 5.
REQ-031 reset asserted during BUSY with grant3 high -> grant3=0 next cycle, out_owner=0, pointer back to 1; next req1+req3 grants 1.
REQ-032 req2 pulsed one cycle then dropped before busy -> grant2 high one cycle, then IDLE, no timeout.
REQ-033 Assertion throughout: $onehot0 of {grant3,grant2,grant1} and out_owner consistent with grants every cycle.
